// File: rtl/dart_scheduler_pkg.sv
// Shared types and defaults for the Monte-Carlo dart scheduler.
package dart_scheduler_pkg;

    localparam int unsigned COORD_W_DEF   = 9;
    localparam int unsigned SIDE_DEF      = 472;
    localparam int unsigned NUM_DARTS_DEF = 1000;
    localparam int unsigned CNT_W_DEF     = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GET_X   = 3'd1,
        ST_GET_Y   = 3'd2,
        ST_EVAL    = 3'd3,
        ST_PRESENT = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // A run is in progress in every state except IDLE and DONE.
    function automatic logic is_active(input state_e s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

endpackage

// File: rtl/dart_scheduler_circle_test.sv
// Combinational quarter-circle test: x*x + y*y < R*R, unsigned, no truncation.
module circle_test #(
    parameter int unsigned COORD_W = 9,
    parameter int unsigned R       = 472
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               hit_c
);

    localparam int unsigned SQ_W  = 2 * COORD_W;
    localparam int unsigned SUM_W = SQ_W + 1;
    localparam logic [SUM_W-1:0] R_SQ = SUM_W'(R * R);

    logic [SQ_W-1:0]  x_sq_c;
    logic [SQ_W-1:0]  y_sq_c;
    logic [SUM_W-1:0] sum_c;

    // Full-width squares and sum, then compare against the squared radius.
    always_comb begin
        x_sq_c = SQ_W'(x_i) * SQ_W'(x_i);
        y_sq_c = SQ_W'(y_i) * SQ_W'(y_i);
        sum_c  = SUM_W'(x_sq_c) + SUM_W'(y_sq_c);
        hit_c  = (sum_c < R_SQ);
    end

endmodule

// File: rtl/dart_scheduler.sv
// Dart scheduler: rejection-samples x/y from the LFSR, classifies each dart
// against the quarter circle, hands it to the plotter and keeps run counts.
module dart_scheduler
    import dart_scheduler_pkg::*;
#(
    parameter int unsigned COORD_W   = COORD_W_DEF,
    parameter int unsigned SIDE      = SIDE_DEF,
    parameter int unsigned NUM_DARTS = NUM_DARTS_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] rand_in,
    input  logic               start,
    input  logic               stop,
    input  logic               dart_ready,
    output logic               dart_valid,
    output logic [COORD_W-1:0] dart_x,
    output logic [COORD_W-1:0] dart_y,
    output logic               dart_hit,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   total_count,
    output logic               busy,
    output logic               done
);

    // One bit wider than the coordinate so SIDE == 2**COORD_W still compares correctly.
    localparam logic [COORD_W:0]  SIDE_W    = (COORD_W + 1)'(SIDE);
    localparam logic [CNT_W-1:0]  LAST_TOT  = CNT_W'(NUM_DARTS - 1);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d;
    logic [COORD_W-1:0] y_q, y_d;
    logic               hit_q, hit_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   tot_q, tot_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               coord_ok_c;
    logic               last_dart_c;
    logic               hit_c;

    circle_test #(
        .COORD_W (COORD_W),
        .R       (SIDE)
    ) u_circle_test (
        .x_i   (x_q),
        .y_i   (y_q),
        .hit_c (hit_c)
    );

    // Sample acceptance and end-of-run detection.
    always_comb begin
        coord_ok_c  = ({1'b0, rand_in} < SIDE_W);
        last_dart_c = (tot_q == LAST_TOT);
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; stop takes priority except that a same-cycle handshake still completes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (!stop && start) state_d = ST_GET_X;
            end
            ST_GET_X: begin
                if (stop)            state_d = ST_DONE;
                else if (coord_ok_c) state_d = ST_GET_Y;
            end
            ST_GET_Y: begin
                if (stop)            state_d = ST_DONE;
                else if (coord_ok_c) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                state_d = stop ? ST_DONE : ST_PRESENT;
            end
            ST_PRESENT: begin
                if (dart_ready)  state_d = (stop || last_dart_c) ? ST_DONE : ST_GET_X;
                else if (stop)   state_d = ST_DONE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values; status flags follow the next state so they stay registered.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        hit_d     = hit_q;
        hit_cnt_d = hit_cnt_q;
        tot_d     = tot_q;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (!stop && start) begin
                    hit_cnt_d = '0;
                    tot_d     = '0;
                end
            end
            ST_GET_X: begin
                if (!stop && coord_ok_c) x_d = rand_in;
            end
            ST_GET_Y: begin
                if (!stop && coord_ok_c) y_d = rand_in;
            end
            ST_EVAL: begin
                if (!stop) hit_d = hit_c;
            end
            ST_PRESENT: begin
                if (dart_ready) begin
                    tot_d     = tot_q + CNT_W'(1);
                    hit_cnt_d = hit_cnt_q + CNT_W'(hit_q);
                end
            end
            default: ;
        endcase
        valid_d = (state_d == ST_PRESENT);
        busy_d  = is_active(state_d);
        done_d  = (state_d == ST_DONE);
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            hit_q     <= 1'b0;
            hit_cnt_q <= '0;
            tot_q     <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            hit_q     <= hit_d;
            hit_cnt_q <= hit_cnt_d;
            tot_q     <= tot_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign dart_valid  = valid_q;
    assign dart_x      = x_q;
    assign dart_y      = y_q;
    assign dart_hit    = hit_q;
    assign hit_count   = hit_cnt_q;
    assign total_count = tot_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_dart_scheduler.sv
// Directed bench for dart_scheduler with a transaction-rule model and per-cycle compare.
module tb_dart_scheduler;

    localparam int COORD_W   = 9;
    localparam int SIDE      = 472;
    localparam int NUM_DARTS = 4;
    localparam int CNT_W     = 16;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [COORD_W-1:0] rand_in = '0;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic               dart_ready = 1'b0;
    logic               dart_valid;
    logic [COORD_W-1:0] dart_x;
    logic [COORD_W-1:0] dart_y;
    logic               dart_hit;
    logic [CNT_W-1:0]   hit_count;
    logic [CNT_W-1:0]   total_count;
    logic               busy;
    logic               done;

    int n_checks = 0;
    int n_errors = 0;

    dart_scheduler #(
        .COORD_W   (COORD_W),
        .SIDE      (SIDE),
        .NUM_DARTS (NUM_DARTS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rand_in     (rand_in),
        .start       (start),
        .stop        (stop),
        .dart_ready  (dart_ready),
        .dart_valid  (dart_valid),
        .dart_x      (dart_x),
        .dart_y      (dart_y),
        .dart_hit    (dart_hit),
        .hit_count   (hit_count),
        .total_count (total_count),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Model: what the run should be doing, in plain integers.
    // phase: 0 idle, 1 want x, 2 want y, 3 classify, 4 offering dart, 5 finished
    int m_phase = 0;
    int m_x = 0, m_y = 0, m_hit = 0, m_tot = 0, m_hits = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock from the inputs present before the edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0; m_x = 0; m_y = 0; m_hit = 0; m_tot = 0; m_hits = 0;
        end else begin
            case (m_phase)
                0, 5: if (!stop && start) begin
                    m_tot = 0; m_hits = 0; m_phase = 1;
                end
                1: if (stop) m_phase = 5;
                   else if (int'(rand_in) < SIDE) begin m_x = int'(rand_in); m_phase = 2; end
                2: if (stop) m_phase = 5;
                   else if (int'(rand_in) < SIDE) begin m_y = int'(rand_in); m_phase = 3; end
                3: if (stop) m_phase = 5;
                   else begin
                       m_hit = (m_x * m_x + m_y * m_y < SIDE * SIDE) ? 1 : 0;
                       m_phase = 4;
                   end
                4: if (dart_ready) begin
                       m_tot++;
                       m_hits += m_hit;
                       m_phase = (stop || m_tot == NUM_DARTS) ? 5 : 1;
                   end else if (stop) m_phase = 5;
                default: m_phase = 0;
            endcase
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        chk("dart_valid",  32'(dart_valid),  32'(m_phase == 4));
        chk("busy",        32'(busy),        32'(m_phase >= 1 && m_phase <= 4));
        chk("done",        32'(done),        32'(m_phase == 5));
        chk("dart_x",      32'(dart_x),      32'(m_x));
        chk("dart_y",      32'(dart_y),      32'(m_y));
        chk("dart_hit",    32'(dart_hit),    32'(m_hit));
        chk("total_count", 32'(total_count), 32'(m_tot));
        chk("hit_count",   32'(hit_count),   32'(m_hits));
    end

    // Apply inputs for one cycle; returns 1 time unit after the sampling edge.
    task automatic cyc(input int r, input logic s, input logic sp, input logic rdy);
        rand_in = COORD_W'(r);
        start = s;
        stop = sp;
        dart_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", 32'(dart_valid), 32'd0);
        chk("reset_total", 32'(total_count), 32'd0);
        chk("reset_busy",  32'(busy), 32'd0);
        reset = 1'b0;
        cyc(0, 0, 0, 1);

        // Start then x=100, y=200: valid appears four edges after the start cycle begins
        cyc(0, 1, 0, 1);
        cyc(100, 0, 0, 1);
        cyc(200, 0, 0, 1);
        chk("lat_valid_early", 32'(dart_valid), 32'd0);
        cyc(0, 0, 0, 1);
        chk("t2_valid", 32'(dart_valid), 32'd1);
        chk("t2_x", 32'(dart_x), 32'd100);
        chk("t2_y", 32'(dart_y), 32'd200);
        chk("t2_hit", 32'(dart_hit), 32'd1);
        cyc(0, 0, 0, 1);
        chk("t2_total", 32'(total_count), 32'd1);
        chk("t2_hits", 32'(hit_count), 32'd1);

        // Rejects 480 and 472, then 471/471 misses (443682 >= 222784)
        cyc(480, 0, 0, 1);
        cyc(472, 0, 0, 1);
        chk("t3_still_x", 32'(busy), 32'd1);
        cyc(471, 0, 0, 1);
        cyc(471, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("t3_x", 32'(dart_x), 32'd471);
        chk("t3_y", 32'(dart_y), 32'd471);
        chk("t3_hit", 32'(dart_hit), 32'd0);
        cyc(0, 0, 0, 1);
        chk("t3_total", 32'(total_count), 32'd2);
        chk("t3_hits", 32'(hit_count), 32'd1);

        // Origin is a hit; then hold ready low for five cycles
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        chk("t3_origin_hit", 32'(dart_hit), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(i + 7, 0, 0, 0);
            chk("t4_hold_valid", 32'(dart_valid), 32'd1);
            chk("t4_hold_x", 32'(dart_x), 32'd0);
            chk("t4_hold_total", 32'(total_count), 32'd2);
        end
        cyc(0, 0, 0, 1);
        chk("t4_total", 32'(total_count), 32'd3);
        chk("t4_hits", 32'(hit_count), 32'd2);

        // Async reset while a dart is on offer
        cyc(5, 0, 0, 0);
        cyc(6, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("t1_pre_valid", 32'(dart_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t1_valid", 32'(dart_valid), 32'd0);
        chk("t1_x", 32'(dart_x), 32'd0);
        chk("t1_y", 32'(dart_y), 32'd0);
        chk("t1_total", 32'(total_count), 32'd0);
        chk("t1_hits", 32'(hit_count), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Full run of four darts at the origin
        cyc(0, 1, 0, 1);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_total", 32'(total_count), 32'd4);
        chk("t5_hits", 32'(hit_count), 32'd4);
        cyc(0, 0, 0, 1);
        chk("t5_held", 32'(total_count), 32'd4);
        cyc(0, 1, 0, 1);
        chk("t5_restart_total", 32'(total_count), 32'd0);
        chk("t5_restart_busy", 32'(busy), 32'd1);

        // start while busy is ignored; dart (3,4) counts, then stop in GET_Y
        cyc(3, 1, 0, 1);
        cyc(4, 1, 0, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        chk("t6_total", 32'(total_count), 32'd1);
        cyc(9, 0, 0, 1);
        cyc(0, 0, 1, 1);
        chk("t6_stop_done", 32'(done), 32'd1);
        chk("t6_stop_total", 32'(total_count), 32'd1);
        chk("t6_stop_y", 32'(dart_y), 32'd4);
        cyc(0, 1, 1, 1);
        chk("t6_startstop_done", 32'(done), 32'd1);
        chk("t6_startstop_total", 32'(total_count), 32'd1);

        // stop while offering without ready: dart dropped
        cyc(0, 1, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("drop_total", 32'(total_count), 32'd0);
        chk("drop_valid", 32'(dart_valid), 32'd0);

        // stop with ready in the same cycle: handshake counts
        cyc(0, 1, 0, 0);
        cyc(2, 0, 0, 0);
        cyc(2, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 1);
        chk("stopready_total", 32'(total_count), 32'd1);
        chk("stopready_hits", 32'(hit_count), 32'd1);
        chk("stopready_done", 32'(done), 32'd1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
